// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu
// Description : Load-store unit. Turns core requests into word-aligned memory
//               transactions, stalls the core until the memory answers, and
//               extends load data. Flags misaligned/illegal accesses and timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic        w_legal;
    logic        w_aligned;
    logic        w_ok;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b0;
        case (core_size_i)
            3'd0: begin w_legal = 1'b1;       w_aligned = 1'b1;                     end
            3'd1: begin w_legal = 1'b1;       w_aligned = ~core_addr_i[0];          end
            3'd2: begin w_legal = 1'b1;       w_aligned = (core_addr_i[1:0] == 2'b00); end
            3'd4: begin w_legal = ~core_we_i; w_aligned = 1'b1;                     end
            3'd5: begin w_legal = ~core_we_i; w_aligned = ~core_addr_i[0];          end
            default: begin w_legal = 1'b0;    w_aligned = 1'b0;                     end
        endcase
    end

    assign w_ok = w_legal & w_aligned;

    // Lane selection uses size[1:0] so that BU/HU share the B/H enables
    always_comb begin
        mem_be_o = 4'b1111;
        mem_wd_o = core_wd_i;
        case (core_size_i[1:0])
            2'b00: begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            2'b01: begin
                mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            default: begin
                mem_be_o = 4'b1111;
                mem_wd_o = core_wd_i;
            end
        endcase
    end

    assign mem_we_o   = core_we_i;
    assign mem_addr_o = {core_addr_i[31:2], 2'b00};

    assign w_byte = mem_rd_i[{core_addr_i[1:0], 3'b000} +: 8];
    assign w_half = mem_rd_i[{core_addr_i[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = mem_rd_i;
        case (core_size_i)
            3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_load_data = {24'd0, w_byte};
            3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
            3'd5:    w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rd_i;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        mem_req_o    = 1'b0;
        core_stall_o = 1'b0;
        misalign_o   = 1'b0;
        bus_err_o    = 1'b0;
        core_rd_o    = 32'd0;
        // Reset silences every output so nothing is captured or reported
        if (!rst_i) begin
            case (r_state)
                S_IDLE: begin
                    if (core_req_i) begin
                        if (!w_ok) begin
                            misalign_o = 1'b1;
                        end else begin
                            mem_req_o = 1'b1;
                            if (!(core_we_i && mem_ready_i)) begin
                                core_stall_o = 1'b1;
                                w_state_nxt  = S_WAIT;
                                w_cnt_nxt    = '0;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (!core_req_i) begin
                        w_state_nxt = S_IDLE;
                    end else if (mem_ready_i) begin
                        mem_req_o   = w_ok;
                        w_state_nxt = S_IDLE;
                        if (!core_we_i) begin
                            core_rd_o = w_load_data;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        bus_err_o   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        mem_req_o    = w_ok;
                        core_stall_o = 1'b1;
                        w_cnt_nxt    = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_lsu
// Description : Randomized self-checking bench for riscv_lsu against a
//               transaction-level model of the load-store unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;

    localparam int c_TO = 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic        mis;
    logic        berr;
    logic        mreq;
    logic        mwe;
    logic [3:0]  mbe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] mrd;
    logic        ready;

    riscv_lsu #(.TIMEOUT(c_TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .core_req_i   (req),
        .core_we_i    (we),
        .core_size_i  (size),
        .core_addr_i  (addr),
        .core_wd_i    (wd),
        .core_rd_o    (rd),
        .core_stall_o (stall),
        .misalign_o   (mis),
        .bus_err_o    (berr),
        .mem_req_o    (mreq),
        .mem_we_o     (mwe),
        .mem_be_o     (mbe),
        .mem_addr_o   (maddr),
        .mem_wd_o     (mwd),
        .mem_rd_i     (mrd),
        .mem_ready_i  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // 0: no check, 1: full check, 2: only pulses and load data (must be zero)
    int          e_mode = 0;
    logic        e_req, e_stall, e_mis, e_err, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_rd, e_wd, e_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (e_mode != 0) begin
            chk("misalign", 32'(mis), 32'(e_mis));
            chk("bus_err", 32'(berr), 32'(e_err));
            chk("core_rd", rd, e_rd);
            if (e_mode == 1) begin
                chk("mem_req", 32'(mreq), 32'(e_req));
                chk("stall", 32'(stall), 32'(e_stall));
                chk("mem_addr", maddr, e_addr);
                if (e_req) begin
                    chk("mem_we", 32'(mwe), 32'(e_we));
                    chk("mem_be", 32'(mbe), 32'(e_be));
                    chk("mem_wd", mwd, e_wd);
                end
            end
        end
    end

    function automatic int nbytes(input logic [2:0] sz);
        case (sz[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_ok(input logic w, input logic [2:0] sz, input logic [31:0] a);
        bit legal;
        legal = (sz <= 3'd2) || (!w && (sz == 3'd4 || sz == 3'd5));
        return legal && ((a % nbytes(sz)) == 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] a);
        int v;
        v = ((1 << nbytes(sz)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = nbytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a,
                                           input logic [31:0] word);
        logic [31:0] sh, mask;
        int n;
        n  = nbytes(sz);
        sh = word >> (8 * (a % 4));
        if (n == 4) return sh;
        mask = (32'h1 << (8 * n)) - 32'h1;
        sh   = sh & mask;
        if (!sz[2] && sh[8*n-1]) sh = sh | ~mask;
        return sh;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        e_mode  = 1;
        e_req   = 1'b0;
        e_stall = 1'b0;
        e_mis   = 1'b0;
        e_err   = 1'b0;
        e_rd    = 32'd0;
        e_addr  = addr & 32'hFFFF_FFFC;
    endtask

    // dly = cycles of mem_ready_i low before the memory answers
    task automatic txn(input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] word, input int dly);
        int z;
        req = 1'b1; we = w; size = sz; addr = a; wd = d; mrd = $urandom;
        exp_idle();
        e_we = w;
        e_be = m_be(sz, a);
        e_wd = m_wd(sz, d);
        if (!m_ok(w, sz, a)) begin
            e_mis = 1'b1;
            ready = 1'($urandom);
            cyc();
        end else begin
            e_req = 1'b1;
            ready = w ? (dly == 0) : 1'($urandom);
            if (w && dly == 0) begin
                cyc();
            end else begin
                e_stall = 1'b1;
                cyc();
                z = w ? dly - 1 : dly;
                for (int k = 0; k < c_TO; k++) begin
                    mrd = $urandom;
                    if (k == z) begin
                        ready = 1'b1;
                        if (!w) mrd = word;
                        e_req = 1'b1; e_stall = 1'b0;
                        e_rd  = w ? 32'd0 : m_load(sz, a, word);
                        cyc();
                        break;
                    end
                    ready = 1'b0;
                    if (k == c_TO - 1) begin
                        e_req = 1'b0; e_stall = 1'b0; e_err = 1'b1; e_rd = 32'd0;
                    end else begin
                        e_req = 1'b1; e_stall = 1'b1;
                    end
                    cyc();
                end
            end
        end
        req = 1'b0; ready = 1'($urandom); mrd = $urandom;
        exp_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] sizes [8];
        sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 3'd2; addr = 32'd0; wd = 32'd0;
        mrd = 32'd0; ready = 1'b0;
        e_mode = 2; e_mis = 1'b0; e_err = 1'b0; e_rd = 32'd0;
        e_req = 1'b0; e_stall = 1'b0; e_we = 1'b0; e_be = 4'd0; e_wd = 32'd0; e_addr = 32'd0;
        cyc(); cyc();
        rst = 1'b0;
        exp_idle();
        cyc(); cyc();

        chk("pin_lw", m_load(3'd2, 32'h10, 32'hDEADBEEF), 32'hDEADBEEF);
        chk("pin_lb", m_load(3'd0, 32'h13, 32'h80FF0000), 32'hFFFFFF80);
        chk("pin_lbu", m_load(3'd4, 32'h13, 32'h80FF0000), 32'h00000080);
        chk("pin_lhu", m_load(3'd5, 32'h12, 32'h80FF0000), 32'h000080FF);
        chk("pin_sb_be", 32'(m_be(3'd0, 32'h01)), 32'h2);
        chk("pin_sb_wd", m_wd(3'd0, 32'h55), 32'h55555555);

        // Literal store: SH addr 0x06
        req = 1'b1; we = 1'b1; size = 3'd1; addr = 32'h6; wd = 32'h1234ABCD; ready = 1'b1;
        e_mode = 1; e_req = 1'b1; e_stall = 1'b0; e_mis = 1'b0; e_err = 1'b0; e_rd = 32'd0;
        e_we = 1'b1; e_be = 4'b1100; e_wd = 32'hABCDABCD; e_addr = 32'h4;
        cyc();
        req = 1'b0; exp_idle(); cyc();

        txn(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        txn(1'b0, 3'd0, 32'h13, 32'h0, 32'h80FF0000, 1);
        txn(1'b0, 3'd4, 32'h13, 32'h0, 32'h80FF0000, 0);
        txn(1'b0, 3'd5, 32'h12, 32'h0, 32'h80FF0000, 2);
        txn(1'b1, 3'd0, 32'h01, 32'h55, 32'h0, 0);
        txn(1'b1, 3'd2, 32'h08, 32'hCAFEF00D, 32'h0, 2);
        txn(1'b0, 3'd1, 32'h03, 32'h0, 32'h0, 0);
        txn(1'b0, 3'd2, 32'h02, 32'h0, 32'h0, 0);
        txn(1'b0, 3'd3, 32'h00, 32'h0, 32'h0, 0);
        txn(1'b0, 3'd2, 32'h20, 32'h0, 32'h12345678, 10);
        txn(1'b0, 3'd1, 32'h22, 32'h0, 32'h8001_7FFF, c_TO - 1);

        // Reset in the middle of a wait
        req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h40; ready = 1'b0;
        exp_idle(); e_req = 1'b1; e_stall = 1'b1; e_we = 1'b0; e_be = 4'hF; e_wd = wd;
        cyc(); cyc();
        rst = 1'b1; e_mode = 2;
        cyc();
        rst = 1'b0; req = 1'b0; exp_idle();
        cyc();
        txn(1'b0, 3'd2, 32'h44, 32'h0, 32'h0BADF00D, 0);

        // Request dropped while waiting
        req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h80; ready = 1'b0;
        exp_idle(); e_req = 1'b1; e_stall = 1'b1; e_we = 1'b0; e_be = 4'hF; e_wd = wd;
        cyc();
        req = 1'b0; e_mode = 2; e_mis = 1'b0; e_err = 1'b0; e_rd = 32'd0;
        cyc();
        txn(1'b0, 3'd0, 32'h81, 32'h0, 32'h0000_9900, 0);

        for (int i = 0; i < 300; i++) begin
            logic w;
            w = ($urandom_range(0, 2) == 0);
            txn(w, sizes[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                $urandom_range(0, c_TO + 1));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                addr = $urandom; exp_idle(); cyc();
            end
        end

        e_mode = 0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
